// File: rtl/transducer_output_module.sv
// Single-channel transmit pulse generator: armed by the controller, fired by the
// external trigger, waits a phase delay, then drives a clamped-width charge pulse.
module transducer_output_module #(
   parameter int PHASE_W    = 16,
   parameter int CHARGE_W   = 9,
   parameter int MAX_CHARGE = 500
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mask,
   input  logic                onYourMark,
   input  logic                getSet,
   input  logic                GOGOGO_EXCLAMATION,
   input  logic [CHARGE_W-1:0] chargeTime,
   input  logic [PHASE_W-1:0]  phaseDelay,
   output logic                transducerOutput,
   output logic                fireComplete
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      DELAY  = 3'd2,
      CHARGE = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [CHARGE_W-1:0] MAX_CHARGE_C = CHARGE_W'(MAX_CHARGE);
   localparam logic [CHARGE_W-1:0] C_ZERO       = {CHARGE_W{1'b0}};
   localparam logic [CHARGE_W-1:0] C_ONE        = {{(CHARGE_W-1){1'b0}}, 1'b1};
   localparam logic [PHASE_W-1:0]  P_ZERO       = {PHASE_W{1'b0}};
   localparam logic [PHASE_W-1:0]  P_ONE        = {{(PHASE_W-1){1'b0}}, 1'b1};

   // Pulse width can never exceed the safety clamp, whatever the controller asks for.
   function automatic logic [CHARGE_W-1:0] clampCharge(input logic [CHARGE_W-1:0] t);
      if (t > MAX_CHARGE_C) begin
         clampCharge = MAX_CHARGE_C;
      end else begin
         clampCharge = t;
      end
   endfunction

   state_t              state_r, nextState_s;
   logic [PHASE_W-1:0]  dcnt_r, dcntNext_s;
   logic [CHARGE_W-1:0] ccnt_r, ccntNext_s;
   logic [CHARGE_W-1:0] chargeClamped_s;
   logic                goPrev_r;
   logic                go_s;

   assign go_s            = GOGOGO_EXCLAMATION & ~goPrev_r & getSet;
   assign chargeClamped_s = clampCharge(chargeTime);

   // Next-state and counter update; aborts take priority over counting.
   always_comb begin
      nextState_s = state_r;
      dcntNext_s  = dcnt_r;
      ccntNext_s  = ccnt_r;
      case (state_r)
         IDLE: begin
            if (onYourMark) begin
               if (mask) begin
                  nextState_s = ARMED;
               end else begin
                  nextState_s = DONE;
               end
            end else begin
               nextState_s = IDLE;
            end
         end
         ARMED: begin
            if (!onYourMark) begin
               nextState_s = IDLE;
            end else if (!mask) begin
               nextState_s = DONE;
            end else if (go_s) begin
               dcntNext_s = phaseDelay;
               ccntNext_s = chargeClamped_s;
               if (phaseDelay != P_ZERO) begin
                  nextState_s = DELAY;
               end else if (chargeClamped_s != C_ZERO) begin
                  nextState_s = CHARGE;
               end else begin
                  nextState_s = DONE;
               end
            end else begin
               nextState_s = ARMED;
            end
         end
         DELAY: begin
            if (!onYourMark) begin
               nextState_s = IDLE;
            end else if (!mask) begin
               nextState_s = DONE;
            end else if (dcnt_r <= P_ONE) begin
               dcntNext_s = P_ZERO;
               if (ccnt_r != C_ZERO) begin
                  nextState_s = CHARGE;
               end else begin
                  nextState_s = DONE;
               end
            end else begin
               dcntNext_s = dcnt_r - P_ONE;
            end
         end
         CHARGE: begin
            if (!onYourMark) begin
               nextState_s = IDLE;
            end else if (!mask) begin
               nextState_s = DONE;
            end else if (ccnt_r <= C_ONE) begin
               ccntNext_s  = C_ZERO;
               nextState_s = DONE;
            end else begin
               ccntNext_s = ccnt_r - C_ONE;
            end
         end
         DONE: begin
            if (!onYourMark) begin
               nextState_s = IDLE;
            end else begin
               nextState_s = DONE;
            end
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // State, counters, trigger history and outputs; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= IDLE;
         dcnt_r           <= P_ZERO;
         ccnt_r           <= C_ZERO;
         goPrev_r         <= 1'b0;
         transducerOutput <= 1'b0;
         fireComplete     <= 1'b0;
      end else begin
         state_r          <= nextState_s;
         dcnt_r           <= dcntNext_s;
         ccnt_r           <= ccntNext_s;
         goPrev_r         <= GOGOGO_EXCLAMATION;
         transducerOutput <= (nextState_s == CHARGE);
         fireComplete     <= (nextState_s == DONE);
      end
   end

endmodule

// File: tb/tb_transducer_output_module.sv
// Directed bench: each cycle's expected outputs are queued when inputs are driven
// and popped for comparison once the clock edge has produced the DUT's response.
module tb_transducer_output_module;

   logic       clk = 1'b0;
   logic       reset;
   logic       mask;
   logic       onYourMark;
   logic       getSet;
   logic       GOGOGO_EXCLAMATION;
   logic [8:0] chargeTime;
   logic [15:0] phaseDelay;
   logic       transducerOutput;
   logic       fireComplete;

   typedef struct {
      logic  out;
      logic  fc;
      string tag;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   transducer_output_module dut (
      .clk                (clk),
      .reset              (reset),
      .mask               (mask),
      .onYourMark         (onYourMark),
      .getSet             (getSet),
      .GOGOGO_EXCLAMATION (GOGOGO_EXCLAMATION),
      .chargeTime         (chargeTime),
      .phaseDelay         (phaseDelay),
      .transducerOutput   (transducerOutput),
      .fireComplete       (fireComplete)
   );

   // One clock: queue what the outputs must be after this edge, then compare.
   task automatic cyc(input logic eOut, input logic eFc, input string tag);
      exp_t e;
      e.out = eOut;
      e.fc  = eFc;
      e.tag = tag;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      checks++;
      assert (transducerOutput === e.out) else begin
         errors++;
         $error("FAIL %s.out: got %b expected %b", e.tag, transducerOutput, e.out);
      end
      checks++;
      assert (fireComplete === e.fc) else begin
         errors++;
         $error("FAIL %s.fc: got %b expected %b", e.tag, fireComplete, e.fc);
      end
   endtask

   task automatic run(input int n, input logic eOut, input logic eFc, input string tag);
      for (int i = 0; i < n; i++) begin
         cyc(eOut, eFc, tag);
      end
   endtask

   initial begin
      reset = 1'b1; mask = 1'b1; onYourMark = 1'b0; getSet = 1'b1;
      GOGOGO_EXCLAMATION = 1'b0; chargeTime = 9'd0; phaseDelay = 16'd0;
      cyc(1'b0, 1'b0, "reset");
      reset = 1'b0;

      // Normal fire, delay 3 width 5; inputs changed after the latch must not matter
      phaseDelay = 16'd3; chargeTime = 9'd5; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "norm_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "norm_t1");
      GOGOGO_EXCLAMATION = 1'b0; phaseDelay = 16'd9; chargeTime = 9'd1;
      run(2, 1'b0, 1'b0, "norm_delay");
      run(5, 1'b1, 1'b0, "norm_pulse");
      GOGOGO_EXCLAMATION = 1'b1;
      run(3, 1'b0, 1'b1, "norm_done");
      GOGOGO_EXCLAMATION = 1'b0; onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "norm_idle");

      // Zero delay, width 4
      phaseDelay = 16'd0; chargeTime = 9'd4; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "zd_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b1, 1'b0, "zd_t1");
      GOGOGO_EXCLAMATION = 1'b0;
      run(3, 1'b1, 1'b0, "zd_pulse");
      cyc(1'b0, 1'b1, "zd_done");
      onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "zd_idle");

      // Zero width: completes without a pulse
      chargeTime = 9'd0; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "zw_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b1, "zw_done");
      GOGOGO_EXCLAMATION = 1'b0; onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "zw_idle");

      // Masked channel
      mask = 1'b0; chargeTime = 9'd5; onYourMark = 1'b1;
      cyc(1'b0, 1'b1, "mask_done");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b1, "mask_go");
      GOGOGO_EXCLAMATION = 1'b0; onYourMark = 1'b0; mask = 1'b1;
      cyc(1'b0, 1'b0, "mask_idle");

      // Gating: no getSet, then GO held high from before arming, then a clean edge
      onYourMark = 1'b1; getSet = 1'b0;
      cyc(1'b0, 1'b0, "gate_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "gate_noset");
      GOGOGO_EXCLAMATION = 1'b0; getSet = 1'b1; onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "gate_idle");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "gate_held_idle");
      onYourMark = 1'b1;
      run(2, 1'b0, 1'b0, "gate_held_armed");
      GOGOGO_EXCLAMATION = 1'b0; phaseDelay = 16'd1; chargeTime = 9'd2;
      cyc(1'b0, 1'b0, "gate_low");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "gate_t1");
      GOGOGO_EXCLAMATION = 1'b0;
      run(2, 1'b1, 1'b0, "gate_pulse");
      cyc(1'b0, 1'b1, "gate_done");
      onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "gate_end");

      // Clamp: request 511, expect exactly 500 high cycles
      phaseDelay = 16'd0; chargeTime = 9'd511; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "clamp_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b1, 1'b0, "clamp_t1");
      GOGOGO_EXCLAMATION = 1'b0;
      run(499, 1'b1, 1'b0, "clamp_pulse");
      cyc(1'b0, 1'b1, "clamp_done");
      onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "clamp_idle");

      // onYourMark abort mid-CHARGE
      phaseDelay = 16'd2; chargeTime = 9'd10; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "oab_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "oab_t1");
      GOGOGO_EXCLAMATION = 1'b0;
      cyc(1'b0, 1'b0, "oab_delay");
      run(2, 1'b1, 1'b0, "oab_pulse");
      onYourMark = 1'b0;
      run(2, 1'b0, 1'b0, "oab_abort");

      // mask abort during DELAY
      phaseDelay = 16'd5; chargeTime = 9'd3; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "mab_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "mab_t1");
      GOGOGO_EXCLAMATION = 1'b0; mask = 1'b0;
      cyc(1'b0, 1'b1, "mab_done");
      mask = 1'b1; onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "mab_idle");

      // Reset during DELAY, then a re-arm fires normally
      phaseDelay = 16'd4; chargeTime = 9'd3; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "rd_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "rd_t1");
      GOGOGO_EXCLAMATION = 1'b0; reset = 1'b1;
      cyc(1'b0, 1'b0, "rd_reset");
      reset = 1'b0;
      cyc(1'b0, 1'b0, "rd_rearm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b0, 1'b0, "rd_t1b");
      GOGOGO_EXCLAMATION = 1'b0;
      run(3, 1'b0, 1'b0, "rd_delay");
      run(3, 1'b1, 1'b0, "rd_pulse");
      cyc(1'b0, 1'b1, "rd_done");
      onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "rd_idle");

      // Reset during CHARGE
      phaseDelay = 16'd0; chargeTime = 9'd6; onYourMark = 1'b1;
      cyc(1'b0, 1'b0, "rc_arm");
      GOGOGO_EXCLAMATION = 1'b1;
      cyc(1'b1, 1'b0, "rc_t1");
      GOGOGO_EXCLAMATION = 1'b0;
      cyc(1'b1, 1'b0, "rc_pulse");
      reset = 1'b1;
      cyc(1'b0, 1'b0, "rc_reset");
      reset = 1'b0; onYourMark = 1'b0;
      cyc(1'b0, 1'b0, "rc_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
